// File: rtl/vector_test_ctrl.sv
// vector_test_ctrl: replays stored test vectors into a combinational DUT
// and counts mismatches. Each memory word is {valid, inputs, expected}.
// A word with valid=0 ends the run, and so does running off the end of the
// address space.
// Optional build macro VECTOR_TEST_CTRL_ERRLOG_EN adds first_err_addr and
// first_err_in, which record the address and stimulus of the first mismatch
// in a run.
module vector_test_ctrl #(
    parameter int NIN  = 3,
    parameter int NOUT = 1,
    parameter int AW   = 8,
    parameter int EW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mem_en,
    output logic [AW-1:0]        mem_addr,
    input  logic [NIN+NOUT:0]    mem_rdata,
    output logic [NIN-1:0]       dut_in,
    input  logic [NOUT-1:0]      dut_out,
    output logic [AW:0]          vec_count,
    output logic [EW-1:0]        err_count
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
    ,
    output logic [AW-1:0]        first_err_addr,
    output logic [NIN-1:0]       first_err_in
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] APPLY = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [NOUT-1:0] exp_q;
    logic [AW:0]     vec_inc;
    logic            rd_valid;
    logic [NIN-1:0]  rd_in;
    logic [NOUT-1:0] rd_exp;
    logic            mismatch;
    logic            launch;

    assign rd_valid = mem_rdata[NIN+NOUT];
    assign rd_in    = mem_rdata[NIN+NOUT-1:NOUT];
    assign rd_exp   = mem_rdata[NOUT-1:0];

    assign vec_inc  = vec_count + (AW+1)'(1);
    assign mismatch = (dut_out != exp_q);
    // start is honoured only when no run is in progress
    assign launch   = start && ((state == IDLE) || (state == DONE));

    assign busy     = (state == FETCH) || (state == APPLY) || (state == CHECK);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == '0);
    assign mem_en   = (state == FETCH);
    assign mem_addr = vec_count[AW-1:0];

    // Next-state selection for the fetch/apply/check loop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = FETCH;
            FETCH:      state_nxt = APPLY;
            APPLY:      state_nxt = rd_valid ? CHECK : DONE;
            // vec_count never exceeds 2^AW-1 here, so the carry bit of the
            // increment marks exhaustion of the memory
            CHECK:      state_nxt = vec_inc[AW] ? DONE : FETCH;
            default:    state_nxt = IDLE;
        endcase
    end

    // State, stimulus register and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dut_in    <= '0;
            exp_q     <= '0;
            vec_count <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                vec_count <= '0;
                err_count <= '0;
            end
            if ((state == APPLY) && rd_valid) begin
                dut_in <= rd_in;
                exp_q  <= rd_exp;
            end
            if (state == CHECK) begin
                vec_count <= vec_inc;
                if (mismatch && (err_count != '1))
                    err_count <= err_count + EW'(1);
            end
        end
    end

`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
    logic err_seen;

    // Capture address and stimulus of the first mismatch in each run
    always_ff @(posedge clk) begin
        if (reset) begin
            err_seen       <= 1'b0;
            first_err_addr <= '0;
            first_err_in   <= '0;
        end else if (launch) begin
            err_seen       <= 1'b0;
            first_err_addr <= '0;
            first_err_in   <= '0;
        end else if ((state == CHECK) && mismatch && !err_seen) begin
            err_seen       <= 1'b1;
            first_err_addr <= mem_addr;
            first_err_in   <= dut_in;
        end
    end
`endif

endmodule

// File: tb/tb_vector_test_ctrl.sv
// Directed bench for vector_test_ctrl. Three instances share clock and reset:
// A uses the default parameters, B uses AW=2 and C uses EW=2. Each instance
// has its own vector memory and its own model of y = ~b&~c | a&~b.
// Define VECTOR_TEST_CTRL_ERRLOG_EN to include the first-error capture ports
// in the checks.
module tb_vector_test_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic [2:0] busy, done, pass, mem_en;

    always #5 clk = ~clk;

    // y for input index {a,b,c}: bit i holds y(i) = 1,0,0,0,1,1,0,0
    logic [7:0] y_tbl;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: defaults (AW=8, EW=16) ----------------
    logic [7:0]  a_addr;
    logic [4:0]  a_rdata;
    logic [2:0]  a_in;
    logic [0:0]  a_out;
    logic [8:0]  a_vc;
    logic [15:0] a_ec;
    logic [4:0]  mem_a [256];
    int          a_fetches;
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
    logic [7:0]  a_fea;
    logic [2:0]  a_fei;
`endif

    assign a_out[0] = (~a_in[1] & ~a_in[0]) | (a_in[2] & ~a_in[1]);
    always @(posedge clk) if (mem_en[0]) a_rdata <= mem_a[a_addr];
    always @(posedge clk) if (mem_en[0]) a_fetches++;

    vector_test_ctrl u_a (
        .clk(clk), .reset(reset), .start(start[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .mem_en(mem_en[0]), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .dut_in(a_in), .dut_out(a_out), .vec_count(a_vc), .err_count(a_ec)
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
        , .first_err_addr(a_fea), .first_err_in(a_fei)
`endif
    );

    // ---------------- instance B: AW=2 ----------------
    logic [1:0]  b_addr;
    logic [4:0]  b_rdata;
    logic [2:0]  b_in;
    logic [0:0]  b_out;
    logic [2:0]  b_vc;
    logic [15:0] b_ec;
    logic [4:0]  mem_b [4];
    int          b_fetches;
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
    logic [1:0]  b_fea;
    logic [2:0]  b_fei;
`endif

    assign b_out[0] = (~b_in[1] & ~b_in[0]) | (b_in[2] & ~b_in[1]);
    always @(posedge clk) if (mem_en[1]) b_rdata <= mem_b[b_addr];
    always @(posedge clk) if (mem_en[1]) b_fetches++;

    vector_test_ctrl #(.AW(2)) u_b (
        .clk(clk), .reset(reset), .start(start[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .mem_en(mem_en[1]), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .dut_in(b_in), .dut_out(b_out), .vec_count(b_vc), .err_count(b_ec)
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
        , .first_err_addr(b_fea), .first_err_in(b_fei)
`endif
    );

    // ---------------- instance C: EW=2 ----------------
    logic [7:0]  c_addr;
    logic [4:0]  c_rdata;
    logic [2:0]  c_in;
    logic [0:0]  c_out;
    logic [8:0]  c_vc;
    logic [1:0]  c_ec;
    logic [4:0]  mem_c [256];
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
    logic [7:0]  c_fea;
    logic [2:0]  c_fei;
`endif

    assign c_out[0] = (~c_in[1] & ~c_in[0]) | (c_in[2] & ~c_in[1]);
    always @(posedge clk) if (mem_en[2]) c_rdata <= mem_c[c_addr];

    vector_test_ctrl #(.EW(2)) u_c (
        .clk(clk), .reset(reset), .start(start[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .mem_en(mem_en[2]), .mem_addr(c_addr), .mem_rdata(c_rdata),
        .dut_in(c_in), .dut_out(c_out), .vec_count(c_vc), .err_count(c_ec)
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
        , .first_err_addr(c_fea), .first_err_in(c_fei)
`endif
    );

    // Pulse start on instance k, then count edges after the start-sampling
    // edge until done rises (bounded by limit)
    task automatic run_to_done(input int k, input int limit, output int cyc);
        start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
        cyc = 0;
        while (!done[k] && cyc < limit) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    initial begin
        int cyc;
        y_tbl = 8'b0011_0001;
        start = '0;
        reset = 1'b1;
        a_rdata = '0; b_rdata = '0; c_rdata = '0;
        a_fetches = 0; b_fetches = 0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_c[i] = '0;
        end
        // 8 correct vectors, end marker at address 8
        for (int i = 0; i < 8; i++) mem_a[i] = {1'b1, 3'(i), y_tbl[i]};
        for (int i = 0; i < 4; i++) mem_b[i] = {1'b1, 3'(i), y_tbl[i]};
        // 5 vectors with inverted expected values, end marker at address 5
        for (int i = 0; i < 5; i++) mem_c[i] = {1'b1, 3'(i), ~y_tbl[i]};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state ----
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_addr", a_addr, 0);
        check_eq("rst_dut_in", a_in, 0);
        check_eq("rst_vc", a_vc, 0);
        check_eq("rst_ec", a_ec, 0);

        // ---- first mem_en in the cycle right after start is sampled ----
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        check_eq("first_fetch_en", mem_en[0], 1);
        check_eq("first_fetch_addr", a_addr, 0);
        check_eq("first_busy", busy[0], 1);
        cyc = 0;
        while (!done[0] && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        // 3 cycles per vector plus fetch and apply of the end marker
        check_eq("good_cycles", cyc, 26);
        check_eq("good_vc", a_vc, 8);
        check_eq("good_ec", a_ec, 0);
        check_eq("good_pass", pass[0], 1);
        check_eq("good_busy", busy[0], 0);
        check_eq("good_hold_in", a_in, 3'b111);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_sticky", done[0], 1);

        // ---- entry 3 expected flipped ----
        mem_a[3] = {1'b1, 3'b011, 1'b1};
        run_to_done(0, 200, cyc);
        check_eq("err_cycles", cyc, 26);
        check_eq("err_ec", a_ec, 1);
        check_eq("err_pass", pass[0], 0);
        check_eq("err_vc", a_vc, 8);
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
        check_eq("err_first_addr", a_fea, 3);
        check_eq("err_first_in", a_fei, 3'b011);
`endif
        mem_a[3] = {1'b1, 3'b011, 1'b0};

        // ---- start pulsed during CHECK of vector 2 is ignored ----
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("mid_vc_before", a_vc, 2);
        check_eq("mid_in_check", {busy[0], mem_en[0]}, 2'b10);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        check_eq("mid_vc_after", a_vc, 3);
        check_eq("mid_fetch_addr", a_addr, 3);
        check_eq("mid_fetch_en", mem_en[0], 1);
        cyc = 9;
        while (!done[0] && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check_eq("mid_cycles", cyc, 26);
        check_eq("mid_vc", a_vc, 8);
        check_eq("mid_ec", a_ec, 0);
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
        check_eq("mid_first_addr", a_fea, 0);
`endif

        // ---- reset during APPLY of vector 5 ----
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_eq("apply5_state", {busy[0], mem_en[0], a_addr}, {2'b10, 8'd5});
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_eq("abort_busy", busy[0], 0);
        check_eq("abort_done", done[0], 0);
        check_eq("abort_pass", pass[0], 0);
        check_eq("abort_mem_en", mem_en[0], 0);
        check_eq("abort_addr", a_addr, 0);
        check_eq("abort_dut_in", a_in, 0);
        check_eq("abort_vc", a_vc, 0);
        check_eq("abort_ec", a_ec, 0);
        a_fetches = 0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("abort_no_fetch", a_fetches, 0);
        check_eq("abort_idle", {busy[0], done[0]}, 0);

        // ---- end marker at address 0 ----
        mem_a[0] = '0;
        run_to_done(0, 50, cyc);
        check_eq("empty_cycles", cyc, 2);
        check_eq("empty_vc", a_vc, 0);
        check_eq("empty_pass", pass[0], 1);

        // ---- AW=2: memory exhausted after address 3 ----
        b_fetches = 0;
        run_to_done(1, 100, cyc);
        check_eq("aw2_cycles", cyc, 12);
        check_eq("aw2_vc", b_vc, 4);
        check_eq("aw2_ec", b_ec, 0);
        check_eq("aw2_pass", pass[1], 1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("aw2_fetches", b_fetches, 4);

        // ---- EW=2: five mismatches saturate at 3 ----
        run_to_done(2, 100, cyc);
        check_eq("ew2_cycles", cyc, 17);
        check_eq("ew2_vc", c_vc, 5);
        check_eq("ew2_ec", c_ec, 3);
        check_eq("ew2_pass", pass[2], 0);
`ifdef VECTOR_TEST_CTRL_ERRLOG_EN
        check_eq("ew2_first_addr", c_fea, 0);
        check_eq("ew2_first_in", c_fei, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
